// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data SRAM responder: configuration window decode,
// register offsets, CTRL bit positions and the byte-lane merge helper.
package data_sram_responder_pkg;

    localparam logic [31:0] CONF_BASE_DEF = 32'hBFAF_0000;
    localparam logic [31:0] CONF_MASK_DEF = 32'hFFFF_0000;

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_NUM    = 16'h0004;
    localparam logic [15:0] OFF_TIMER  = 16'h0008;
    localparam logic [15:0] OFF_CMP    = 16'h000C;
    localparam logic [15:0] OFF_CTRL   = 16'h0010;
    localparam logic [15:0] OFF_STATUS = 16'h0014;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // Replace each byte lane of old_word whose enable is set with new_word's lane.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_conf_timer.sv
// Configuration registers (LED, NUM, compare timer, CTRL, STATUS) with a
// registered read mux; a request here is already known to hit the window.
module data_sram_responder_conf_timer
    import data_sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [3:0]  we,
    input  logic [15:0] off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq
);

    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        pending_q, pending_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] cur_s;
    logic [31:0] merged_s;
    logic        wr_s;
    logic        match_s;
    logic        clear_s;

    // Read mux, byte-merged writes, timer increment and pending set/clear.
    always_comb begin
        led_d  = led_q;
        num_d  = num_q;
        cmp_d  = cmp_q;
        ctrl_d = ctrl_q;
        case (off)
            OFF_LED:    cur_s = {16'h0000, led_q};
            OFF_NUM:    cur_s = num_q;
            OFF_TIMER:  cur_s = timer_q;
            OFF_CMP:    cur_s = cmp_q;
            OFF_CTRL:   cur_s = {30'h0000_0000, ctrl_q};
            OFF_STATUS: cur_s = {31'h0000_0000, pending_q};
            default:    cur_s = 32'h0000_0000;
        endcase
        merged_s = merge_bytes(cur_s, wdata, we);
        wr_s     = req && (we != 4'b0000);
        match_s  = ctrl_q[CTRL_TIMER_EN] && (timer_q == cmp_q);
        clear_s  = wr_s && (off == OFF_STATUS) && we[0] && wdata[0];

        if (req) begin
            rdata_d = cur_s;
        end else begin
            rdata_d = rdata_q;
        end

        if (ctrl_q[CTRL_TIMER_EN]) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = timer_q;
        end

        if (wr_s) begin
            case (off)
                OFF_LED:   led_d   = merged_s[15:0];
                OFF_NUM:   num_d   = merged_s;
                OFF_TIMER: timer_d = merged_s;
                OFF_CMP:   cmp_d   = merged_s;
                OFF_CTRL:  ctrl_d  = merged_s[1:0];
                default:   ctrl_d  = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end

        // A match in the same cycle as a W1C keeps the interrupt pending.
        if (match_s) begin
            pending_d = 1'b1;
        end else if (clear_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q     <= 16'h0000;
            num_q     <= 32'h0000_0000;
            timer_q   <= 32'h0000_0000;
            cmp_q     <= 32'hFFFF_FFFF;
            ctrl_q    <= 2'b00;
            pending_q <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign led       = led_q;
    assign num_data  = num_q;
    assign timer_irq = pending_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the core's data_sram_* port: word-addressed RAM plus the
// configuration window, both answering with one cycle of read latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
    parameter logic [31:0] CONF_MASK = CONF_MASK_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_irq
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    logic              conf_hit_s;
    logic [ADDR_W-1:0] idx_s;
    logic [31:0]       ram_word_s;
    logic              ram_wr_s;
    logic [31:0]       conf_rdata_s;

    logic        conf_hit_q, conf_hit_d;
    logic [31:0] ram_rdata_q, ram_rdata_d;

    assign conf_hit_s = ((data_sram_addr & CONF_MASK) == CONF_BASE);
    assign idx_s      = data_sram_addr[ADDR_W+1:2];
    assign ram_word_s = mem[idx_s];
    assign ram_wr_s   = resetn && data_sram_en && !conf_hit_s && (data_sram_we != 4'b0000);

    // Capture the RAM word and the source select for the cycle after the request.
    always_comb begin
        if (data_sram_en) begin
            conf_hit_d = conf_hit_s;
            if (!conf_hit_s) begin
                ram_rdata_d = ram_word_s;
            end else begin
                ram_rdata_d = ram_rdata_q;
            end
        end else begin
            conf_hit_d  = conf_hit_q;
            ram_rdata_d = ram_rdata_q;
        end
    end

    // RAM write port; contents survive reset, writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            mem[idx_s] <= merge_bytes(ram_word_s, data_sram_wdata, data_sram_we);
        end
    end

    // Read-path registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            conf_hit_q  <= 1'b0;
            ram_rdata_q <= 32'h0000_0000;
        end else begin
            conf_hit_q  <= conf_hit_d;
            ram_rdata_q <= ram_rdata_d;
        end
    end

    data_sram_responder_conf_timer u_conf_timer (
        .clk       (clk),
        .resetn    (resetn),
        .req       (data_sram_en && conf_hit_s),
        .we        (data_sram_we),
        .off       (data_sram_addr[15:0]),
        .wdata     (data_sram_wdata),
        .rdata     (conf_rdata_s),
        .led       (led),
        .num_data  (num_data),
        .timer_irq (timer_irq)
    );

    // Final select between the two registered read sources.
    always_comb begin
        if (conf_hit_q) begin
            data_sram_rdata = conf_rdata_s;
        end else begin
            data_sram_rdata = ram_rdata_q;
        end
    end

endmodule
